// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the byte-stream instruction memory loader.
// Covers the FSM encoding, the nop word and the header width.
package imem_stream_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam int          HDR_W = 16;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a byte stream into big-endian 32-bit words.
// The first byte of a word ends up in [31:24] and the fourth in [7:0].
module imem_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  rx_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_reg;
  logic [23:0] shift_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_reg  <= 2'd0;
      shift_reg <= 24'd0;
    end else if (clear) begin
      lane_reg  <= 2'd0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[15:0], rx_data};
      lane_reg  <= lane_reg + 2'd1;
    end
  end

  // The fourth byte is passed straight through so the word can be written on its own edge.
  assign word_valid = shift_en && (lane_reg == 2'd3);
  assign word       = {shift_reg, rx_data};

endmodule

// File: rtl/imem_stream_loader.sv
// Writable instruction memory. A 16-bit word-count header followed by big-endian words
// is streamed in byte by byte, and the CPU is held until the load completes.
module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int ROM_SIZE = 128,
  parameter int ROM_BIT  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic [31:0]      addr,
  output logic [31:0]      instruction,
  output logic             cpu_hold,
  output logic             load_busy,
  output logic             load_done,
  output logic             overflow,
  output logic [ROM_BIT:0] words_loaded
);

  localparam logic [ROM_BIT:0] ROM_WORDS = (ROM_BIT + 1)'(ROM_SIZE);

  state_t             state_reg, state_next;
  logic [HDR_W-1:0]   len_reg, len_next;
  logic [HDR_W-1:0]   cnt_reg, cnt_next;
  logic [ROM_BIT:0]   wl_reg, wl_next;
  logic               ov_reg, ov_next;
  logic               asm_clear, asm_shift, mem_we;
  logic               word_valid;
  logic [31:0]        asm_word;
  logic [HDR_W-1:0]   hdr_word;
  logic [31:0]        mem [ROM_SIZE];
  logic               unused_addr;

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .shift_en   (asm_shift),
    .rx_data    (rx_data),
    .word_valid (word_valid),
    .word       (asm_word)
  );

  assign hdr_word = {len_reg[15:8], rx_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      wl_reg    <= '0;
      ov_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      wl_reg    <= wl_next;
      ov_reg    <= ov_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    wl_next    = wl_reg;
    ov_next    = ov_reg;
    asm_clear  = 1'b0;
    asm_shift  = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LEN_HI;
          ov_next    = 1'b0;
          wl_next    = '0;
          cnt_next   = '0;
          asm_clear  = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_next[15:8] = rx_data;
          state_next     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_next[7:0] = rx_data;
          state_next    = (hdr_word == '0) ? ST_DONE : ST_DATA;
          if (hdr_word > HDR_W'(ROM_SIZE)) ov_next = 1'b1;
        end
      end
      ST_DATA: begin
        asm_shift = rx_valid;
        if (word_valid) begin
          // Words past the end of memory are consumed but dropped; the raw count still
          // tracks the header so the session terminates.
          mem_we   = (wl_reg < ROM_WORDS);
          if (wl_reg < ROM_WORDS) wl_next = wl_reg + 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_next == len_reg) state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory contents are deliberately left out of reset so a program survives it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wl_reg[ROM_BIT-1:0]] <= asm_word;
  end

  assign cpu_hold     = (state_reg != ST_IDLE);
  assign load_busy    = cpu_hold;
  assign load_done    = (state_reg == ST_DONE);
  assign overflow     = ov_reg;
  assign words_loaded = wl_reg;
  assign instruction  = cpu_hold ? NOP : mem[addr[ROM_BIT+1:2]];
  assign unused_addr  = ^{addr[31:ROM_BIT+2], addr[1:0]};

endmodule
